// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Bank of CHANNELS independent event counters. Each counter either wraps or
//   saturates, depending on SATURATE. The bank also provides atomic snapshot,
//   freeze, clear and a registered readout port for the display path.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   rst        synchronous, active-high reset (overrides everything)
//   en         global count enable
//   clear      synchronous clear of counters, shadows, flags and readout
//   freeze     level; while high, counters hold and ignore inc
//   snapshot   copies every live counter (pre-edge value) into its shadow
//   inc        per-channel +1 strobe
//   sel        readout channel select; out-of-range selects read 0
//   live_out   registered live value of the selected channel
//   snap_out   registered shadow value of the selected channel
//   overflow   sticky per-channel wrap/saturation flag
//   snap_valid high once a snapshot has been taken since the last rst/clear
module perf_counter_bank #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned SEL_WIDTH   = 2,
   parameter bit          SATURATE    = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clear,
   input  logic                   freeze,
   input  logic                   snapshot,
   input  logic [CHANNELS-1:0]    inc,
   input  logic [SEL_WIDTH-1:0]   sel,
   output logic [COUNT_WIDTH-1:0] live_out,
   output logic [COUNT_WIDTH-1:0] snap_out,
   output logic [CHANNELS-1:0]    overflow,
   output logic                   snap_valid
);

   logic [COUNT_WIDTH-1:0] cnt_q    [CHANNELS];
   logic [COUNT_WIDTH-1:0] cnt_d    [CHANNELS];
   logic [COUNT_WIDTH-1:0] shadow_q [CHANNELS];
   logic [COUNT_WIDTH-1:0] shadow_d [CHANNELS];
   logic [CHANNELS-1:0]    ovf_q, ovf_d;
   logic [COUNT_WIDTH-1:0] live_q, live_d;
   logic [COUNT_WIDTH-1:0] snap_q, snap_d;
   logic                   snap_valid_q, snap_valid_d;
   logic                   count_ok;

   always_comb begin
      count_ok     = en & ~freeze;
      ovf_d        = ovf_q;
      snap_valid_d = snap_valid_q | snapshot;
      live_d       = '0;
      snap_d       = '0;

      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cnt_d[i]    = cnt_q[i];
         // Shadow takes the pre-edge count, so a same-cycle increment is excluded.
         shadow_d[i] = snapshot ? cnt_q[i] : shadow_q[i];

         if (count_ok && inc[i]) begin
            if (&cnt_q[i]) begin
               ovf_d[i] = 1'b1;
               if (!SATURATE) begin
                  cnt_d[i] = '0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
         end

         // Unmatched (out-of-range) selects leave the readout at 0.
         if (sel == SEL_WIDTH'(i)) begin
            live_d = cnt_q[i];
            snap_d = shadow_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
         ovf_q        <= '0;
         live_q       <= '0;
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_q[i]    <= cnt_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         ovf_q        <= ovf_d;
         live_q       <= live_d;
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   assign live_out   = live_q;
   assign snap_out   = snap_q;
   assign overflow   = ovf_q;
   assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank
//   Drives two instances from shared stimulus. The first is a 4-channel, 4-bit
//   wrapping bank. The second is a 3-channel, 4-bit saturating bank. Both are
//   checked every cycle against a per-instance arithmetic reference model, and
//   directed constant checks cover the key scenarios.
module tb_perf_counter_bank;

   localparam int MAXV = 15;

   logic       clk = 1'b0;
   logic       rst, en, clear, freeze, snapshot;
   logic [3:0] inc;
   logic [1:0] sel;

   logic [3:0] live_a, snap_a, ovf_a;
   logic       sv_a;
   logic [3:0] live_b, snap_b;
   logic [2:0] ovf_b;
   logic       sv_b;

   int total = 0;
   int bad   = 0;

   // Reference model state: index 0 = wrapping bank, 1 = saturating bank
   int m_cnt  [2][4];
   int m_shd  [2][4];
   int m_ovf  [2][4];
   int m_live [2];
   int m_snap [2];
   int m_sv   [2];
   int m_ch   [2] = '{4, 3};
   int m_sat  [2] = '{0, 1};

   perf_counter_bank #(
      .CHANNELS(4), .COUNT_WIDTH(4), .SEL_WIDTH(2), .SATURATE(1'b0)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .freeze(freeze),
      .snapshot(snapshot), .inc(inc), .sel(sel), .live_out(live_a),
      .snap_out(snap_a), .overflow(ovf_a), .snap_valid(sv_a)
   );

   perf_counter_bank #(
      .CHANNELS(3), .COUNT_WIDTH(4), .SEL_WIDTH(2), .SATURATE(1'b1)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .freeze(freeze),
      .snapshot(snapshot), .inc(inc[2:0]), .sel(sel), .live_out(live_b),
      .snap_out(snap_b), .overflow(ovf_b), .snap_valid(sv_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One rising edge of behaviour, computed from the pre-edge model state.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst || clear) begin
            for (int i = 0; i < 4; i++) begin
               m_cnt[k][i] = 0;
               m_shd[k][i] = 0;
               m_ovf[k][i] = 0;
            end
            m_live[k] = 0;
            m_snap[k] = 0;
            m_sv[k]   = 0;
         end else begin
            m_live[k] = (int'(sel) < m_ch[k]) ? m_cnt[k][sel] : 0;
            m_snap[k] = (int'(sel) < m_ch[k]) ? m_shd[k][sel] : 0;
            if (snapshot) begin
               for (int i = 0; i < 4; i++) m_shd[k][i] = m_cnt[k][i];
               m_sv[k] = 1;
            end
            for (int i = 0; i < m_ch[k]; i++) begin
               if (en && !freeze && inc[i]) begin
                  if (m_cnt[k][i] == MAXV) m_ovf[k][i] = 1;
                  if (!(m_sat[k] == 1 && m_cnt[k][i] == MAXV))
                     m_cnt[k][i] = (m_cnt[k][i] + 1) % (MAXV + 1);
               end
            end
         end
      end
   endtask

   function automatic logic [31:0] ovf_bits(input int k);
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++) v[i] = (m_ovf[k][i] != 0);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("a_live", 32'(live_a), 32'(m_live[0]));
      check("a_snap", 32'(snap_a), 32'(m_snap[0]));
      check("a_ovf",  32'(ovf_a),  ovf_bits(0));
      check("a_sv",   32'(sv_a),   32'(m_sv[0]));
      check("b_live", 32'(live_b), 32'(m_live[1]));
      check("b_snap", 32'(snap_b), 32'(m_snap[1]));
      check("b_ovf",  32'(ovf_b),  ovf_bits(1));
      check("b_sv",   32'(sv_b),   32'(m_sv[1]));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[k][i] = 0;
            m_shd[k][i] = 0;
            m_ovf[k][i] = 0;
         end
         m_live[k] = 0;
         m_snap[k] = 0;
         m_sv[k]   = 0;
      end
      rst = 1'b1; en = 1'b1; clear = 1'b0; freeze = 1'b0; snapshot = 1'b0;
      inc = 4'b1111; sel = 2'd0;

      // Reset held with increments pending, then idle release
      ticks(3);
      rst = 1'b0; inc = 4'b0000;
      tick();
      check("rst_live", 32'(live_a), 32'd0);
      check("rst_ovf",  32'(ovf_a),  32'd0);
      check("rst_sv",   32'(sv_a),   32'd0);

      // Basic count on channels 0 and 2
      inc = 4'b0101;
      ticks(10);
      inc = 4'b0000;
      tick();
      check("basic_ch0", 32'(live_a), 32'd10);
      sel = 2'd2;
      tick();
      check("basic_ch2", 32'(live_a), 32'd10);
      sel = 2'd1;
      tick();
      check("basic_ch1", 32'(live_a), 32'd0);
      sel = 2'd3;
      tick();
      check("basic_ch3", 32'(live_a), 32'd0);
      check("b_sel_oob", 32'(live_b), 32'd0);

      // Wrap on channel 0 (saturates on the second bank)
      clear = 1'b1;
      tick();
      clear = 1'b0; inc = 4'b0001; sel = 2'd0;
      ticks(17);
      inc = 4'b0000;
      tick();
      check("wrap_live", 32'(live_a), 32'd1);
      check("wrap_ovf",  32'(ovf_a),  32'b0001);
      check("sat0_live", 32'(live_b), 32'd15);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      check("clr_live", 32'(live_a), 32'd0);
      check("clr_ovf",  32'(ovf_a),  32'd0);

      // Saturate on channel 1, then keep pushing
      inc = 4'b0010; sel = 2'd1;
      ticks(20);
      inc = 4'b0000;
      tick();
      check("sat_live", 32'(live_b), 32'd15);
      check("sat_ovf",  32'(ovf_b),  32'b010);
      inc = 4'b0010;
      ticks(3);
      inc = 4'b0000;
      tick();
      check("sat_hold", 32'(live_b), 32'd15);

      // Snapshot racing an increment
      clear = 1'b1;
      tick();
      clear = 1'b0; inc = 4'b0100;
      ticks(7);
      snapshot = 1'b1;
      tick();
      snapshot = 1'b0; inc = 4'b0000; sel = 2'd2;
      tick();
      check("race_snap", 32'(snap_a), 32'd7);
      check("race_live", 32'(live_a), 32'd8);
      check("race_sv",   32'(sv_a),   32'd1);

      // Gating: freeze then en=0, with a snapshot while frozen
      inc = 4'b1111; freeze = 1'b1;
      ticks(2);
      snapshot = 1'b1;
      tick();
      snapshot = 1'b0;
      ticks(2);
      freeze = 1'b0; en = 1'b0;
      ticks(5);
      en = 1'b1; inc = 4'b0000;
      tick();
      check("gate_live", 32'(live_a), 32'd8);
      check("gate_snap", 32'(snap_a), 32'd8);
      sel = 2'd3;
      tick();
      check("gate_oob_b", 32'(live_b), 32'd0);

      // Reset mid-count, counting resumes from 0
      inc = 4'b1111; sel = 2'd0;
      ticks(4);
      rst = 1'b1;
      tick();
      rst = 1'b0; inc = 4'b0001;
      tick();
      inc = 4'b0000;
      tick();
      check("rst_mid", 32'(live_a), 32'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 99) == 0);
         clear    = ($urandom_range(0, 49) == 0);
         en       = ($urandom_range(0, 9) != 0);
         freeze   = ($urandom_range(0, 7) == 0);
         snapshot = ($urandom_range(0, 9) == 0);
         inc      = 4'($urandom);
         sel      = 2'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of event counters that generalises the CPU's fixed statistics counters (cycle count, correct predictions, mispredictions) into CHANNELS independent channels. Each channel has a configurable width and a selectable wrap or saturate mode. The bank supports atomic snapshot, freeze and clear, plus a registered, selectable readout port that feeds the seven-segment display path. It sits beside the pipeline: per-channel increment strobes come from the pipeline, and the readout goes to the display mux, with switch_addr-style selection.

Parameters:
CHANNELS, 4, number of independent counters (1..16)
COUNT_WIDTH, 32, width of each counter and of the readout
SEL_WIDTH, 2, width of sel; must satisfy 2**SEL_WIDTH >= CHANNELS
SATURATE, 0, 0 = counters wrap to 0 after all-ones; 1 = counters hold at all-ones

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
en  input  1  global count enable; low pauses every channel
clear  input  1  synchronous clear of all counters, shadows and overflow flags
freeze  input  1  level; while high, counters hold and ignore inc
snapshot  input  1  one-cycle pulse; copies all live counters into shadow registers
inc  input  CHANNELS  per-channel increment strobe, +1 per cycle while high
sel  input  SEL_WIDTH  channel select for readout
live_out  output  COUNT_WIDTH  registered live value of the selected channel
snap_out  output  COUNT_WIDTH  registered shadow value of the selected channel
overflow  output  CHANNELS  sticky per-channel overflow/saturation flag
snap_valid  output  1  high once a snapshot has been taken since the last rst/clear

Behaviour:
- Reset (rst=1 at an edge): all counters, shadows, live_out, snap_out, overflow and snap_valid go to 0. rst overrides every other input.
- Priority at each edge: rst > clear > counting/snapshot.
- clear=1: same result as reset for all state. Snapshot and inc in the same cycle are ignored.
- Counting condition for channel i: en & ~freeze & inc[i]. The counter updates at the same edge; no internal latency beyond the register.
- Wrap mode (SATURATE=0): all-ones + 1 becomes 0 and sets overflow[i].
- Saturate mode (SATURATE=1): at all-ones the counter holds and overflow[i] is set. Further incs leave both unchanged.
- overflow[i] is sticky. Only rst or clear clears it.
- snapshot=1 (and no rst/clear): every shadow[i] takes the counter's pre-edge value, so an increment in the same cycle is excluded. snap_valid goes to 1.
- snapshot is honoured while frozen or while en=0.
- A snapshot held high for several cycles re-captures on every cycle.
- Readout: live_out and snap_out are registered with 1-cycle latency from sel or counter change.
  - At edge N they show the value of channel sel as it was before edge N.
  - If sel >= CHANNELS, both read 0.
- freeze and en only gate counting. They affect neither readout nor snapshot.
- Width rule: the increment is exactly +1 modulo 2**COUNT_WIDTH. There is no carry between channels.
- Reset mid-count: the counter is 0 at the reset edge, and counting resumes from 0 on the first edge with rst=0.

Test Plan:
- Reset/idle: hold rst 3 cycles with inc all ones, then release with inc=0 → all outputs 0, snap_valid=0.
- Basic count: en=1, inc=4'b0101 for 10 cycles, sel=0 then sel=2 → live_out=10 for both channels; channels 1 and 3 read 0; sel=3 readout appears 1 cycle after sel changes.
- Wrap (COUNT_WIDTH=4, SATURATE=0): 17 incs on channel 0 → live_out=1, overflow=4'b0001. clear → live_out=0, overflow=0.
- Saturate (COUNT_WIDTH=4, SATURATE=1): 20 incs on channel 1 → value 15, overflow[1]=1, and it stays 15.
- Snapshot race: channel 2 at 7 with inc[2]=1 and snapshot=1 in the same cycle → snap_out(sel=2)=7, live_out=8, snap_valid=1.
- Gating: freeze=1 for 5 cycles, then en=0 for 5 cycles, inc high throughout → counters unchanged. A snapshot during freeze still captures. sel=3 with CHANNELS=3 reads 0.
